// File: rtl/bpu_pkg.sv
// Shared encodings for the branch predict unit: control-class codes seen in
// ID, PC mux select codes, and 2-bit counter initial values.
package bpu_pkg;

  // Control class of the instruction currently in ID.
  typedef enum logic [2:0] {
    JB_OTHERS = 3'd0,
    JB_BEQ    = 3'd1,
    JB_BNE    = 3'd2,
    JB_JR     = 3'd3,
    JB_J      = 3'd4,
    JB_JAL    = 3'd7
  } jb_e;

  // Next-PC mux select driven towards the fetch stage.
  typedef enum logic [2:0] {
    PC_SEQ     = 3'd0,  // pc+4, or if_pred_target when IF predicts taken
    PC_BR      = 3'd1,  // conditional branch target from ID
    PC_JMP     = 3'd2,  // direct jump target from ID
    PC_JR      = 3'd3,  // register jump target from ID
    PC_RECOVER = 3'd4   // id_pc+4 after a wrongly predicted taken
  } pc_src_e;

  // Counter values: after reset (weakly not-taken), and on allocation.
  localparam logic [1:0] CTR_RESET     = 2'd1;
  localparam logic [1:0] CTR_ALLOC_BR  = 2'd2;
  localparam logic [1:0] CTR_ALLOC_JMP = 2'd3;

  // True for the classes that train the table (everything but JR/OTHERS).
  function automatic logic trains_table(input logic [2:0] jb);
    return (jb == JB_BEQ) || (jb == JB_BNE) || (jb == JB_J) || (jb == JB_JAL);
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating up/down counter.
module sat_counter2 (
  input  logic [1:0] ctr_q,
  input  logic       inc,
  output logic [1:0] ctr_d
);

  // Step towards 3 when inc, towards 0 otherwise, holding at the ends.
  always_comb begin
    ctr_d = ctr_q;
    if (inc) begin
      if (ctr_q != 2'd3) ctr_d = ctr_q + 2'd1;
    end else begin
      if (ctr_q != 2'd0) ctr_d = ctr_q - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters. IF looks up combinationally; ID
// resolves branches/jumps, raises flush and selects the next PC, and trains
// the table at the clock edge (reads in the same cycle see the old entry).
// Optional resolve/mispredict statistics are built when BPU_STATS_EN is
// defined; otherwise branch_cnt and mispred_cnt are constant 0.
//
// Qualification: an ID instruction acts (resolves, flushes, trains, counts)
// only in a cycle where id_valid=1 and id_stall=0; any other cycle is a no-op
// for ID regardless of the remaining id_* inputs.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [PC_W-1:0] if_pred_target,
  input  logic            id_valid,
  input  logic            id_stall,
  input  logic [2:0]      id_jump_branch,
  input  logic            id_equ,
  input  logic [PC_W-1:0] id_pc,
  input  logic [PC_W-1:0] id_target,
  input  logic            id_pred_taken,
  input  logic [PC_W-1:0] id_pred_target,
  output logic            id_flush,
  output logic [2:0]      pc_src,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W - 2;

  // Table storage
  logic [DEPTH-1:0] tbl_valid;
  logic [1:0]       tbl_ctr [DEPTH];
  logic [TAG_W-1:0] tbl_tag [DEPTH];
  logic [PC_W-1:0]  tbl_tgt [DEPTH];

  // Word-aligned PCs: the low two bits carry no information here.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], id_pc[1:0]};

  // IF-side lookup
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign if_hit = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);

  // ID-side decode
  logic             resolve;
  logic             is_cond;
  logic             is_jmp;
  logic             is_jr;
  logic             actual_taken;
  logic             mispredict;
  logic             upd_en;
  logic [IDX_W-1:0] id_idx;
  logic [TAG_W-1:0] id_tag;
  logic             id_hit;
  logic [1:0]       id_ctr;
  logic [1:0]       ctr_next;

  assign is_cond = (id_jump_branch == JB_BEQ) || (id_jump_branch == JB_BNE);
  assign is_jmp  = (id_jump_branch == JB_J) || (id_jump_branch == JB_JAL);
  assign is_jr   = (id_jump_branch == JB_JR);
  assign resolve = id_valid && !id_stall && (id_jump_branch != JB_OTHERS);
  assign upd_en  = resolve && trains_table(id_jump_branch);

  assign id_idx = id_pc[IDX_W+1:2];
  assign id_tag = id_pc[PC_W-1:IDX_W+2];
  assign id_hit = tbl_valid[id_idx] && (tbl_tag[id_idx] == id_tag);
  assign id_ctr = tbl_ctr[id_idx];

  // Resolve the real direction and compare with what IF guessed.
  always_comb begin
    actual_taken = is_jmp || is_jr ||
                   ((id_jump_branch == JB_BEQ) && id_equ) ||
                   ((id_jump_branch == JB_BNE) && !id_equ);
    mispredict   = 1'b0;
    if (is_cond || is_jmp) begin
      mispredict = (id_pred_taken != actual_taken) ||
                   (id_pred_taken && actual_taken && (id_pred_target != id_target));
    end
  end

  assign id_flush = resolve && (mispredict || is_jr);

  // Next-PC select, highest priority first.
  always_comb begin
    pc_src = PC_SEQ;
    if (resolve && is_jr) begin
      pc_src = PC_JR;
    end else if (resolve && mispredict && actual_taken) begin
      pc_src = is_cond ? PC_BR : PC_JMP;
    end else if (resolve && mispredict) begin
      pc_src = PC_RECOVER;
    end
  end

  // Prediction is suppressed while ID is redirecting fetch anyway.
  always_comb begin
    if_pred_taken  = if_hit && tbl_ctr[if_idx][1] && !id_flush;
    if_pred_target = if_pred_taken ? tbl_tgt[if_idx] : '0;
  end

  sat_counter2 u_sat_counter2 (
    .ctr_q (id_ctr),
    .inc   (actual_taken),
    .ctr_d (ctr_next)
  );

  // Valid bits and counters: reset, saturating update on hit, allocate on taken miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_ctr[i] <= CTR_RESET;
      end
    end else if (upd_en) begin
      if (id_hit) begin
        tbl_ctr[id_idx] <= ctr_next;
      end else if (actual_taken) begin
        tbl_valid[id_idx] <= 1'b1;
        tbl_ctr[id_idx]   <= is_cond ? CTR_ALLOC_BR : CTR_ALLOC_JMP;
      end
    end
  end

  // Tag and target: written on any taken training (hit rewrite or allocation).
  always_ff @(posedge clk) begin
    if (!rst && upd_en && actual_taken) begin
      tbl_tag[id_idx] <= id_tag;
      tbl_tgt[id_idx] <= id_target;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_q;

  // Wrapping counters of resolved control transfers and of flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (resolve)  branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (id_flush) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`else
  assign branch_cnt  = '0;
  assign mispred_cnt = '0;
`endif

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL use one clock and a synchronous active-high reset: ports clk and rst.
REQ-002 SHALL take parameters:
  - PC_W, 32, PC width.
  - IDX_W, 4, BTB index width; table depth is 2**IDX_W.
REQ-003 SHALL have these ports (name, direction, width, meaning):
  - clk, in, 1, clock.
  - rst, in, 1, sync reset, active-high.
  - if_pc, in, PC_W, fetch PC.
  - if_pred_taken, out, 1, IF predicts taken.
  - if_pred_target, out, PC_W, predicted next PC.
  - id_valid, in, 1, ID holds a real instruction.
  - id_stall, in, 1, ID is held this cycle.
  - id_jump_branch, in, 3, control class: OTHERS=0, BEQ=1, BNE=2, JR=3, J=4, JAL=7.
  - id_equ, in, 1, register compare equal.
  - id_pc, in, PC_W, PC of the ID instruction.
  - id_target, in, PC_W, computed branch/jump target.
  - id_pred_taken, in, 1, prediction carried from IF.
  - id_pred_target, in, PC_W, prediction target carried from IF.
  - id_flush, out, 1, squash IF/ID.
  - pc_src, out, 3, PC mux select.
  - branch_cnt, out, 32, resolved branches/jumps.
  - mispred_cnt, out, 32, mispredictions.

Function
REQ-004 SHALL hold 2**IDX_W direct-mapped entries, each with a valid bit, tag, target (PC_W) and a 2-bit saturating counter; index = pc[IDX_W+1:2], tag = pc[PC_W-1:IDX_W+2].
REQ-005 SHALL look up combinationally in the same cycle: if_pred_taken = hit AND counter[1] AND NOT id_flush; if_pred_target = the entry target, or 0 when not predicting.
REQ-006 SHALL define resolve = id_valid AND NOT id_stall AND id_jump_branch != OTHERS; actual_taken = (J|JAL|JR) OR (BEQ AND id_equ) OR (BNE AND NOT id_equ).
REQ-007 SHALL define mispredict for BEQ, BNE, J and JAL as: id_pred_taken != actual_taken, or both taken and id_pred_target != id_target.
REQ-008 SHALL drive id_flush = resolve AND (mispredict OR id_jump_branch==JR), combinationally.
REQ-009 SHALL drive pc_src, combinationally, by priority:
  - JR resolve gives 3.
  - Mispredict with actual_taken gives 1 for BEQ/BNE and 2 for J/JAL.
  - Mispredict with not-taken gives 4 (recover to id_pc+4).
  - Otherwise 0 (sequential, or if_pred_target when if_pred_taken).
REQ-010 SHALL update the entry of id_pc at the clock edge when resolve is high and the class is not JR:
  - Hit: counter increments if taken, decrements if not, saturating at 0 and 3; target rewritten when taken.
  - Miss and taken: allocate (valid=1, tag, target), counter 2 for BEQ/BNE, 3 for J/JAL.
  - Miss and not taken: no change.
REQ-011 SHALL never allocate or update an entry for JR; JR always flushes.
REQ-012 SHALL give read-before-write: an IF lookup to the index being updated in the same cycle sees the old contents; the update is visible the next cycle.
REQ-013 SHALL perform no update and assert no flush while id_stall=1 or id_valid=0.

Reset
REQ-014 SHALL, on rst at a clock edge: clear all valid bits, counters to 1 (weakly not-taken), and branch_cnt and mispred_cnt to 0.
REQ-015 SHALL give rst priority over a simultaneous update; the outputs are combinational, so when every entry is invalid they give if_pred_taken=0 and if_pred_target=0.

Configuration
REQ-016 SHALL compile statistics in under macro BPU_STATS_EN:
  - Defined: branch_cnt increments on every resolve; mispred_cnt increments on every id_flush.
  - Both counters are 32-bit and wrap.
  - Not defined: both ports are tied to 0 and the counters are absent.

Structure
REQ-017 SHALL put the following in package bpu_pkg: the id_jump_branch encodings, the pc_src encodings (0 SEQ, 1 BR, 2 JMP, 3 JR, 4 RECOVER) and the counter init constants.
REQ-018 SHALL use one sub-module, sat_counter2 (2-bit saturating next-state logic), instantiated per update path.

Verification
REQ-019 SHALL cover:
  - Cold BEQ taken: id_pc=0x40, equ=1, pred 0, target 0x80. Expect id_flush=1, pc_src=1. Next cycle, if_pc=0x40 gives pred_taken=1, target 0x80.
  - BEQ trained to 3, then equ=0 with pred 1. Expect id_flush=1, pc_src=4, counter 2; still predicts taken.
  - JR at 0x100. Expect id_flush=1, pc_src=3, no allocation (if_pc=0x100 gives pred_taken=0).
  - Same-cycle update and IF lookup of 0x40. IF sees old entry; next cycle sees new.
  - id_stall=1 with a mispredicting BNE. Expect no flush and no update.
  - rst mid-training. All predictions 0, counters 0. With BPU_STATS_EN, 3 branches and 1 mispredict give 3/1.
